proc_top: RTL and testbench

// Processing-element side of the OpenNoc image pipeline; sits beside the mesh NoC top and owns one local NoC port per node.

---
 rtl/proc_top.sv | 130 +++++++++++++
 tb/tb_proc_top.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/proc_top.sv
// OpenNoc image pipeline processing elements: node 0 bridges host bytes
// into the mesh, worker nodes answer each pixel with its inverse.
module proc_top #(
  parameter int X       = 2,
  parameter int Y       = 2,
  parameter int DATA_W  = 8,
  parameter int X_W     = (X > 1) ? $clog2(X) : 1,
  parameter int Y_W     = (Y > 1) ? $clog2(Y) : 1,
  parameter int TOTAL_W = DATA_W + X_W + Y_W
) (
  input  logic                    clk,
  input  logic                    rstn,
  output logic [X*Y-1:0]          r_valid_pe,
  output logic [TOTAL_W*X*Y-1:0]  r_data_pe,
  input  logic [X*Y-1:0]          r_ready_pe,
  input  logic [X*Y-1:0]          w_valid_pe,
  input  logic [TOTAL_W*X*Y-1:0]  w_data_pe,
  input  logic                    i_valid_pci,
  input  logic [7:0]              i_data_pci,
  output logic                    o_ready_pci,
  output logic [7:0]              o_data_pci,
  output logic                    o_valid_pci,
  input  logic                    i_ready_pci
);

  localparam int N     = X * Y;
  localparam int HW    = X_W + Y_W;
  localparam int PW    = (N > 1) ? $clog2(N) : 1;
  localparam int FIRST = (N > 1) ? 1 : 0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  logic [1:0]         r_state;
  logic               r_rdy;
  logic               r_hv;
  logic [TOTAL_W-1:0] r_hpkt;
  logic               r_ov;
  logic [7:0]         r_od;
  logic [PW-1:0]      r_ptr;
  logic [N-1:0]       w_unused_dst;

  function automatic logic [HW-1:0] f_dest(input logic [PW-1:0] n);
    int v;
    v = int'(n);
    f_dest = {Y_W'(v / X), X_W'(v % X)};
  endfunction

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_state <= S_IDLE;
      r_rdy   <= 1'b0;
      r_hv    <= 1'b0;
      r_hpkt  <= '0;
      r_ov    <= 1'b0;
      r_od    <= '0;
      r_ptr   <= PW'(FIRST);
    end else begin
      case (r_state)
        S_IDLE: begin
          r_rdy <= 1'b1;
          if (i_valid_pci && r_rdy) begin
            r_rdy   <= 1'b0;
            r_hv    <= 1'b1;
            r_hpkt  <= {DATA_W'(i_data_pci), f_dest(r_ptr)};
            r_state <= S_SEND;
          end
        end
        S_SEND: begin
          if (r_ready_pe[0]) begin
            r_hv    <= 1'b0;
            r_ptr   <= (r_ptr >= PW'(N - 1)) ? PW'(FIRST)
                                             : r_ptr + PW'(1);
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_valid_pe[0]) begin
            r_od    <= 8'(w_data_pe[HW +: DATA_W]);
            r_ov    <= 1'b1;
            r_state <= S_OUT;
          end
        end
        S_OUT: begin
          if (i_ready_pci) begin
            r_ov    <= 1'b0;
            r_rdy   <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_ready_pci            = r_rdy;
  assign o_valid_pci            = r_ov;
  assign o_data_pci             = r_od;
  assign r_valid_pe[0]          = r_hv;
  assign r_data_pe[TOTAL_W-1:0] = r_hpkt;

  // Received dest fields carry no information for any node.
  for (genvar d = 0; d < N; d++) begin : g_dst
    assign w_unused_dst[d] = ^w_data_pe[d*TOTAL_W +: HW];
  end

  for (genvar n = 1; n < N; n++) begin : g_wk
    logic              r_v;
    logic [DATA_W-1:0] r_p;

    always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
        r_v <= 1'b0;
        r_p <= '0;
      end else if (w_valid_pe[n]) begin
        r_v <= 1'b1;
        r_p <= DATA_W'(8'd255)
             - w_data_pe[n*TOTAL_W + HW +: DATA_W];
      end else if (r_ready_pe[n]) begin
        r_v <= 1'b0;
      end
    end

    assign r_valid_pe[n] = r_v;
    assign r_data_pe[n*TOTAL_W +: TOTAL_W] = {r_p, {HW{1'b0}}};
  end

endmodule

// File: tb/tb_proc_top.sv
// Bench for proc_top: random host traffic through a loopback mesh model,
// checked against an in-order inverse-pixel reference.
module tb_proc_top;

  localparam int X  = 2;
  localparam int Y  = 2;
  localparam int DW = 8;
  localparam int XW = 1;
  localparam int YW = 1;
  localparam int HW = XW + YW;
  localparam int TW = DW + HW;
  localparam int N  = X * Y;
  localparam int NB = 300;

  logic            clk = 1'b0;
  logic            rstn = 1'b1;
  logic [N-1:0]    r_valid_pe;
  logic [TW*N-1:0] r_data_pe;
  logic [N-1:0]    r_ready_pe = '0;
  logic [N-1:0]    w_valid_pe = '0;
  logic [TW*N-1:0] w_data_pe = '0;
  logic            i_valid_pci = 1'b0;
  logic [7:0]      i_data_pci = '0;
  logic            o_ready_pci;
  logic [7:0]      o_data_pci;
  logic            o_valid_pci;
  logic            i_ready_pci = 1'b0;

  proc_top #(.X(X), .Y(Y), .DATA_W(DW)) dut (
    .clk(clk), .rstn(rstn),
    .r_valid_pe(r_valid_pe), .r_data_pe(r_data_pe),
    .r_ready_pe(r_ready_pe),
    .w_valid_pe(w_valid_pe), .w_data_pe(w_data_pe),
    .i_valid_pci(i_valid_pci), .i_data_pci(i_data_pci),
    .o_ready_pci(o_ready_pci), .o_data_pci(o_data_pci),
    .o_valid_pci(o_valid_pci), .i_ready_pci(i_ready_pci)
  );

  initial forever #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int node_of(input logic [TW-1:0] p);
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    x = p[XW-1:0];
    y = p[HW-1:XW];
    return int'(y) * X + int'(x);
  endfunction

  logic [7:0] byte_q[$];
  logic [7:0] exp_q[$];

  initial begin
    logic [7:0] infl;
    logic [7:0] e;
    logic [TW-1:0] pk;
    logic [TW-1:0] np_pkt;
    logic [TW-1:0] prev_d0;
    logic [7:0] prev_od;
    bit busy, drop_iv, np_v, lat_in, lat_out;
    bit prev_v0, prev_r0, prev_ov, prev_ir;
    int sent, pkts, outs, exp_w, cycles, np_dly, np_node, lat_wk;
    int run_v0, run_ov;

    infl = '0; pk = '0; np_pkt = '0; prev_d0 = '0; prev_od = '0;
    busy = 0; drop_iv = 0; np_v = 0; lat_in = 0; lat_out = 0;
    prev_v0 = 0; prev_r0 = 0; prev_ov = 0; prev_ir = 0;
    sent = 0; pkts = 0; outs = 0; exp_w = 1; cycles = 0;
    np_dly = 0; np_node = 0; lat_wk = -1; run_v0 = 0; run_ov = 0;

    byte_q.push_back(8'h00);
    byte_q.push_back(8'h10);
    byte_q.push_back(8'h20);
    byte_q.push_back(8'h30);
    byte_q.push_back(8'h40);
    for (int i = 5; i < NB; i++) byte_q.push_back(8'($urandom));

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_rvalid", 32'(r_valid_pe), 0);
      check("rst_rdata", 32'(|r_data_pe), 0);
      check("rst_ordy", 32'(o_ready_pci), 0);
      check("rst_ovld", 32'(o_valid_pci), 0);
      check("rst_odata", 32'(o_data_pci), 0);
    end
    @(posedge clk);
    #1 rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rdy_rel", 32'(o_ready_pci), 1);

    while (outs < NB && cycles < 20000) begin
      @(posedge clk);
      #1;
      w_valid_pe = '0;
      w_data_pe  = '0;
      if (np_v) begin
        if (np_dly == 0) begin
          w_valid_pe[np_node] = 1'b1;
          w_data_pe[np_node*TW +: TW] = np_pkt;
          np_v = 0;
        end else begin
          np_dly--;
        end
      end
      if (drop_iv) begin
        i_valid_pci = 1'b0;
        drop_iv = 0;
      end
      if (!i_valid_pci && sent < NB && $urandom_range(0, 3) != 0) begin
        i_valid_pci = 1'b1;
        i_data_pci  = byte_q[sent];
      end
      for (int n = 0; n < N; n++)
        r_ready_pe[n] = ($urandom_range(0, 3) != 0);
      if (pkts == 5) r_ready_pe[0] = (run_v0 >= 10);
      i_ready_pci = (outs == 6) ? (run_ov >= 10)
                                : ($urandom_range(0, 3) != 0);

      @(negedge clk);
      cycles++;
      if (lat_in) check("lat_in", 32'(r_valid_pe[0]), 1);
      if (lat_wk >= 0) check("lat_wk", 32'(r_valid_pe[lat_wk]), 1);
      if (lat_out) check("lat_out", 32'(o_valid_pci), 1);
      lat_in = 0; lat_wk = -1; lat_out = 0;

      if (prev_v0 && !prev_r0) begin
        check("hold_v0", 32'(r_valid_pe[0]), 1);
        check("hold_d0", 32'(r_data_pe[TW-1:0]), 32'(prev_d0));
      end
      if (prev_ov && !prev_ir) begin
        check("hold_ov", 32'(o_valid_pci), 1);
        check("hold_od", 32'(o_data_pci), 32'(prev_od));
      end
      check(busy ? "rdy_busy" : "rdy_idle", 32'(o_ready_pci),
            busy ? 0 : 1);

      if (i_valid_pci && o_ready_pci) begin
        infl = i_data_pci;
        exp_q.push_back(8'hFF - i_data_pci);
        busy = 1; sent++; lat_in = 1; drop_iv = 1;
      end
      if (r_valid_pe[0] && r_ready_pe[0]) begin
        pk = r_data_pe[TW-1:0];
        check("dest", 32'(node_of(pk)), 32'(exp_w));
        check("pay0", 32'(pk[TW-1:HW]), 32'(infl));
        exp_w = (exp_w == N - 1) ? 1 : exp_w + 1;
        pkts++;
        np_v = 1; np_node = node_of(pk); np_pkt = pk;
        np_dly = $urandom_range(0, 3);
      end
      for (int n = 1; n < N; n++) begin
        if (r_valid_pe[n] && r_ready_pe[n]) begin
          pk = r_data_pe[n*TW +: TW];
          check("wdest", 32'(node_of(pk)), 0);
          check("wpay", 32'(pk[TW-1:HW]), 32'(8'hFF - infl));
          np_v = 1; np_node = node_of(pk); np_pkt = pk;
          np_dly = $urandom_range(0, 3);
        end
      end
      if (w_valid_pe[0]) lat_out = 1;
      for (int n = 1; n < N; n++)
        if (w_valid_pe[n]) lat_wk = n;
      if (o_valid_pci && i_ready_pci) begin
        if (exp_q.size() == 0) begin
          check("extra_out", 32'(o_data_pci), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("out", 32'(o_data_pci), 32'(e));
        end
        busy = 0; outs++;
      end

      prev_v0 = r_valid_pe[0]; prev_r0 = r_ready_pe[0];
      prev_d0 = r_data_pe[TW-1:0];
      prev_ov = o_valid_pci; prev_ir = i_ready_pci;
      prev_od = o_data_pci;
      run_v0 = r_valid_pe[0] ? run_v0 + 1 : 0;
      run_ov = o_valid_pci ? run_ov + 1 : 0;
    end

    check("outputs", 32'(outs), 32'(NB));
    check("leftover", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
